// File: rtl/id_operand_stage_if.sv
// ID-stage bundle: IF/ID instruction, register-file reads, forwarding
// sources, EX-side handshake and the registered ID/EX payload.
interface id_operand_stage_if #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int NUM_FWD        = 3
);
  logic                              in_valid;
  logic                              in_ready;
  logic [PC_WIDTH-1:0]               in_pc;
  logic [REG_ADDR_WIDTH-1:0]         in_rs1;
  logic [REG_ADDR_WIDTH-1:0]         in_rs2;
  logic [REG_ADDR_WIDTH-1:0]         in_rd;
  logic                              in_uses_rs1;
  logic                              in_uses_rs2;
  logic                              in_is_load;
  logic                              in_is_branch;
  logic [2:0]                        in_br_type;
  logic [REG_WIDTH-1:0]              in_imm;
  logic [REG_WIDTH-1:0]              rf_data1;
  logic [REG_WIDTH-1:0]              rf_data2;
  logic [NUM_FWD-1:0]                fwd_valid;
  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd;
  logic [NUM_FWD*REG_WIDTH-1:0]      fwd_data;
  logic                              ex_ready;
  logic                              flush;
  logic                              out_valid;
  logic [PC_WIDTH-1:0]               out_pc;
  logic [REG_WIDTH-1:0]              out_imm;
  logic [REG_WIDTH-1:0]              out_op1;
  logic [REG_WIDTH-1:0]              out_op2;
  logic [REG_ADDR_WIDTH-1:0]         out_rd;
  logic                              out_is_load;
  logic                              br_taken;
  logic [PC_WIDTH-1:0]               br_target;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_is_load, in_is_branch, in_br_type, in_imm, rf_data1, rf_data2,
           fwd_valid, fwd_rd, fwd_data, ex_ready, flush,
    input  in_ready, out_valid, out_pc, out_imm, out_op1, out_op2, out_rd,
           out_is_load, br_taken, br_target
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_is_load, in_is_branch, in_br_type, in_imm, rf_data1, rf_data2,
           fwd_valid, fwd_rd, fwd_data, ex_ready, flush,
    output in_ready, out_valid, out_pc, out_imm, out_op1, out_op2, out_rd,
           out_is_load, br_taken, br_target
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand forwarding, branch resolution, load-use stall and
// wrong-path kill, ending in the registered ID/EX operand register.
module id_operand_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32,
  parameter int NUM_FWD        = 3,
  parameter int LOAD_LAT       = 1
) (
  input logic              clk,
  input logic              reset,
  id_operand_stage_if.slave bus
);
  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  typedef enum logic [1:0] {RUN, LU_STALL, KILL} state_t;

  state_t                    state, state_next;
  logic [1:0]                cnt, cnt_next;
  logic [REG_WIDTH-1:0]      op1, op2;
  logic                      hit1, hit2;
  logic                      taken, hazard, adv, ready, accept;

  logic                      out_valid_q;
  logic [PC_WIDTH-1:0]       out_pc_q;
  logic [REG_WIDTH-1:0]      out_imm_q, out_op1_q, out_op2_q;
  logic [REG_ADDR_WIDTH-1:0] out_rd_q;
  logic                      out_is_load_q;

  // Ascending scan with a hit flag keeps the lowest matching index.
  always_comb begin
    op1  = bus.rf_data1;
    op2  = bus.rf_data2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!hit1 && bus.fwd_valid[i] && bus.in_rs1 != '0 &&
          bus.fwd_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == bus.in_rs1) begin
        op1  = bus.fwd_data[i*REG_WIDTH +: REG_WIDTH];
        hit1 = 1'b1;
      end
      if (!hit2 && bus.fwd_valid[i] && bus.in_rs2 != '0 &&
          bus.fwd_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == bus.in_rs2) begin
        op2  = bus.fwd_data[i*REG_WIDTH +: REG_WIDTH];
        hit2 = 1'b1;
      end
    end
  end

  always_comb begin
    taken = 1'b0;
    case (bus.in_br_type)
      3'b000:  taken = (op1 == op2);
      3'b001:  taken = (op1 != op2);
      3'b100:  taken = ($signed(op1) <  $signed(op2));
      3'b101:  taken = ($signed(op1) >= $signed(op2));
      3'b110:  taken = (op1 <  op2);
      3'b111:  taken = (op1 >= op2);
      default: taken = 1'b0;
    endcase
  end

  assign hazard = out_valid_q & out_is_load_q & (out_rd_q != '0) &
                  ((bus.in_uses_rs1 & (bus.in_rs1 == out_rd_q)) |
                   (bus.in_uses_rs2 & (bus.in_rs2 == out_rd_q)));
  assign adv    = bus.ex_ready | ~out_valid_q;

  always_comb begin
    ready = 1'b0;
    if (!bus.flush) begin
      case (state)
        RUN:     ready = adv & ~hazard;
        KILL:    ready = adv;
        default: ready = 1'b0;
      endcase
    end
  end

  assign accept        = bus.in_valid & ready;
  assign bus.in_ready  = ready;
  assign bus.br_taken  = accept & bus.in_is_branch & taken & (state == RUN);
  assign bus.br_target = bus.in_pc + PC_WIDTH'(bus.in_imm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The stall's final cycle hands back to RUN directly, so the stalled
  // instruction is accepted LOAD_LAT cycles after it first met the hazard.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (bus.flush) begin
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.in_valid && hazard && adv) begin
            cnt_next   = CNT_INIT;
            state_next = (LOAD_LAT > 1) ? LU_STALL : RUN;
          end else if (accept && bus.in_is_branch && taken) begin
            state_next = KILL;
          end
        end
        LU_STALL: begin
          if (cnt <= 2'd1) begin
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
        KILL: begin
          if (accept) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_rd_q      <= '0;
      out_is_load_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= accept & (state == RUN);
      if (accept) begin
        out_pc_q      <= bus.in_pc;
        out_imm_q     <= bus.in_imm;
        out_op1_q     <= op1;
        out_op2_q     <= op2;
        out_rd_q      <= bus.in_rd;
        out_is_load_q <= bus.in_is_load;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_op1     = out_op1_q;
  assign bus.out_op2     = out_op2_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_is_load = out_is_load_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding/branch vector table plus
// load-use, back-pressure, flush and reset sequences.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_operand_stage_if #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32), .NUM_FWD(3)) bus ();

  id_operand_stage #(
    .REG_WIDTH(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32), .NUM_FWD(3), .LOAD_LAT(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic [2:0]  fv;
    logic [4:0]  frd0, frd1, frd2;
    logic [31:0] fd0, fd1, fd2;
    logic        br;
    logic [2:0]  bt;
    logic [31:0] pc, imm;
    logic [31:0] e_op1, e_op2;
    logic        e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] rf1, input logic [31:0] rf2, input logic [2:0] fv,
    input logic [4:0] frd0, input logic [4:0] frd1, input logic [4:0] frd2,
    input logic [31:0] fd0, input logic [31:0] fd1, input logic [31:0] fd2,
    input logic br, input logic [2:0] bt, input logic [31:0] pc, input logic [31:0] imm,
    input logic [31:0] e_op1, input logic [31:0] e_op2, input logic e_tk,
    input logic [31:0] e_tgt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rf1 = rf1; v.rf2 = rf2; v.fv = fv;
    v.frd0 = frd0; v.frd1 = frd1; v.frd2 = frd2;
    v.fd0 = fd0; v.fd1 = fd1; v.fd2 = fd2;
    v.br = br; v.bt = bt; v.pc = pc; v.imm = imm;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;   bus.in_pc = '0;        bus.in_rs1 = '0;
    bus.in_rs2 = '0;       bus.in_rd = 5'd1;      bus.in_uses_rs1 = 1'b0;
    bus.in_uses_rs2 = 1'b0; bus.in_is_load = 1'b0; bus.in_is_branch = 1'b0;
    bus.in_br_type = 3'b010; bus.in_imm = '0;     bus.rf_data1 = '0;
    bus.rf_data2 = '0;     bus.fwd_valid = '0;    bus.fwd_rd = '0;
    bus.fwd_data = '0;     bus.flush = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rs1, input logic [31:0] rf1,
                           input logic [4:0] rd);
    idle();
    bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_uses_rs1 = 1'b1;
    bus.rf_data1 = rf1;  bus.in_rd = rd;   bus.in_pc = 32'h0000_0800;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle();
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_rd = rd;
    bus.in_pc = 32'h0000_0A00;
  endtask

  initial begin
    vecs[0]  = mkv(5'd3, 5'd4, 32'h11, 32'h22, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b0, 3'b000, 32'h000, 32'h4, 32'h11, 32'h22, 1'b0, 32'h004);
    vecs[1]  = mkv(5'd5, 5'd6, 32'h11, 32'h22, 3'b111, 5'd5, 5'd5, 5'd5, 32'hAAA, 32'hBBB, 32'hCCC,
                   1'b0, 3'b000, 32'h010, 32'h4, 32'hAAA, 32'h22, 1'b0, 32'h014);
    vecs[2]  = mkv(5'd0, 5'd0, 32'h33, 32'h44, 3'b111, 5'd0, 5'd0, 5'd0, 32'hAAA, 32'hBBB, 32'hCCC,
                   1'b0, 3'b000, 32'h020, 32'h8, 32'h33, 32'h44, 1'b0, 32'h028);
    vecs[3]  = mkv(5'd5, 5'd5, 32'h33, 32'h44, 3'b110, 5'd5, 5'd5, 5'd5, 32'hAAA, 32'hBBB, 32'hCCC,
                   1'b0, 3'b000, 32'h030, 32'h10, 32'hBBB, 32'hBBB, 1'b0, 32'h040);
    vecs[4]  = mkv(5'd9, 5'd5, 32'h55, 32'h66, 3'b100, 5'd5, 5'd5, 5'd9, 32'hAAA, 32'hBBB, 32'hCCC,
                   1'b0, 3'b000, 32'h040, 32'h0, 32'hCCC, 32'h66, 1'b0, 32'h040);
    vecs[5]  = mkv(5'd1, 5'd2, 32'h10, 32'h10, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b000, 32'h100, 32'h20, 32'h10, 32'h10, 1'b1, 32'h120);
    vecs[6]  = mkv(5'd1, 5'd2, 32'hFFFF_FFFF, 32'h1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b110, 32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1F0);
    vecs[7]  = mkv(5'd1, 5'd2, 32'hFFFF_FFFF, 32'h1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b100, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h208);
    vecs[8]  = mkv(5'd1, 5'd2, 32'h5, 32'h5, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b001, 32'h300, 32'h4, 32'h5, 32'h5, 1'b0, 32'h304);
    vecs[9]  = mkv(5'd1, 5'd2, 32'h1, 32'h2, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b010, 32'h300, 32'h10, 32'h1, 32'h2, 1'b0, 32'h310);
    vecs[10] = mkv(5'd1, 5'd2, 32'h1, 32'hFFFF_FFFF, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b101, 32'h400, 32'h40, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h440);
    vecs[11] = mkv(5'd1, 5'd2, 32'h1, 32'hFFFF_FFFF, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b111, 32'h400, 32'h80, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h480);
    vecs[12] = mkv(5'd5, 5'd2, 32'h0, 32'h77, 3'b001, 5'd5, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0,
                   1'b1, 3'b000, 32'h500, 32'h100, 32'h77, 32'h77, 1'b1, 32'h600);
    vecs[13] = mkv(5'd1, 5'd2, 32'h9, 32'h9, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                   1'b1, 3'b011, 32'h0, 32'h0, 32'h9, 32'h9, 1'b0, 32'h0);

    idle();
    bus.ex_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_out_pc", bus.out_pc, 32'h0);
    chk("reset_out_op1", bus.out_op1, 32'h0);
    chk("reset_out_rd", 32'(bus.out_rd), 32'h0);
    reset = 1'b0;
    #2;
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);

    // Table: operand resolution and branch decode with a streaming EX.
    for (int k = 0; k < 14; k++) begin
      idle();
      bus.in_valid = 1'b1;  bus.in_rs1 = vecs[k].rs1; bus.in_rs2 = vecs[k].rs2;
      bus.in_uses_rs1 = 1'b1; bus.in_uses_rs2 = 1'b1;
      bus.rf_data1 = vecs[k].rf1; bus.rf_data2 = vecs[k].rf2;
      bus.fwd_valid = vecs[k].fv;
      bus.fwd_rd = {vecs[k].frd2, vecs[k].frd1, vecs[k].frd0};
      bus.fwd_data = {vecs[k].fd2, vecs[k].fd1, vecs[k].fd0};
      bus.in_is_branch = vecs[k].br; bus.in_br_type = vecs[k].bt;
      bus.in_pc = vecs[k].pc; bus.in_imm = vecs[k].imm;
      #2;
      chk($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 32'h1);
      chk($sformatf("v%0d_br_taken", k), 32'(bus.br_taken), 32'(vecs[k].e_tk));
      chk($sformatf("v%0d_br_target", k), bus.br_target, vecs[k].e_tgt);
      cyc();
      chk($sformatf("v%0d_out_valid", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("v%0d_out_op1", k), bus.out_op1, vecs[k].e_op1);
      chk($sformatf("v%0d_out_op2", k), bus.out_op2, vecs[k].e_op2);
      chk($sformatf("v%0d_out_pc", k), bus.out_pc, vecs[k].pc);
      if (vecs[k].e_tk) begin
        // Wrong-path slot: a branch that would be taken must be dropped unevaluated.
        idle();
        bus.in_valid = 1'b1; bus.in_is_branch = 1'b1; bus.in_br_type = 3'b000;
        bus.rf_data1 = 32'h3; bus.rf_data2 = 32'h3; bus.in_pc = 32'h900;
        #2;
        chk($sformatf("v%0d_kill_in_ready", k), 32'(bus.in_ready), 32'h1);
        chk($sformatf("v%0d_kill_br_taken", k), 32'(bus.br_taken), 32'h0);
        cyc();
        chk($sformatf("v%0d_kill_out_valid", k), 32'(bus.out_valid), 32'h0);
      end
    end

    // Load to x7, then a consumer of x7 with LOAD_LAT = 2.
    drive_load(5'd7);
    cyc();
    chk("lu_load_valid", 32'(bus.out_valid), 32'h1);
    chk("lu_load_flag", 32'(bus.out_is_load), 32'h1);
    idle();
    bus.in_valid = 1'b1; bus.in_rs2 = 5'd7; bus.in_uses_rs2 = 1'b1; bus.in_rd = 5'd8;
    bus.rf_data2 = 32'h2222;
    #2;
    chk("lu_ready_c0", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("lu_bubble_1", 32'(bus.out_valid), 32'h0);
    #2;
    chk("lu_ready_c1", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("lu_bubble_2", 32'(bus.out_valid), 32'h0);
    #2;
    chk("lu_ready_c2", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("lu_issue_valid", 32'(bus.out_valid), 32'h1);
    chk("lu_issue_rd", 32'(bus.out_rd), 32'h8);
    chk("lu_issue_op2", bus.out_op2, 32'h2222);

    // Back-pressure from EX.
    drive_alu(5'd3, 32'h1234, 5'd3);
    cyc();
    chk("hold_first", bus.out_op1, 32'h1234);
    bus.ex_ready = 1'b0;
    bus.rf_data1 = 32'h5678;
    for (int h = 0; h < 3; h++) begin
      #2;
      chk($sformatf("hold_ready_%0d", h), 32'(bus.in_ready), 32'h0);
      cyc();
      chk($sformatf("hold_valid_%0d", h), 32'(bus.out_valid), 32'h1);
      chk($sformatf("hold_op1_%0d", h), bus.out_op1, 32'h1234);
    end
    bus.ex_ready = 1'b1;
    #2;
    chk("hold_release_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("hold_release_op1", bus.out_op1, 32'h5678);

    // Flush coinciding with a taken branch: no KILL afterwards.
    idle();
    bus.in_valid = 1'b1; bus.in_is_branch = 1'b1; bus.in_br_type = 3'b000;
    bus.rf_data1 = 32'h4; bus.rf_data2 = 32'h4; bus.flush = 1'b1;
    #2;
    chk("flush_br_taken", 32'(bus.br_taken), 32'h0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
    drive_alu(5'd2, 32'h99, 5'd4);
    #2;
    chk("post_flush_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("post_flush_valid", 32'(bus.out_valid), 32'h1);
    chk("post_flush_op1", bus.out_op1, 32'h99);

    // Flush while in the load-use stall.
    drive_load(5'd7);
    cyc();
    drive_alu(5'd7, 32'h31, 5'd9);
    cyc();
    chk("lsf_bubble", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b1;
    #2;
    chk("lsf_in_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    bus.flush = 1'b0;
    chk("lsf_out_valid", 32'(bus.out_valid), 32'h0);
    #2;
    chk("lsf_ready_after", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("lsf_issue", 32'(bus.out_valid), 32'h1);

    // Asynchronous reset in the middle of a stall.
    drive_load(5'd7);
    cyc();
    drive_alu(5'd7, 32'h41, 5'd10);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_pc", bus.out_pc, 32'h0);
    chk("rst_mid_is_load", 32'(bus.out_is_load), 32'h0);
    chk("rst_mid_rd", 32'(bus.out_rd), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("rst_mid_issue", 32'(bus.out_valid), 32'h1);
    chk("rst_mid_op1", bus.out_op1, 32'h41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
